// File: rtl/queue_manager.sv
`default_nettype none
// ============================================================================
// Module   : queue_manager
// Purpose  : Customer-queue controller: occupancy, open-teller count, ticket
//            issue/serve counters and arithmetic expected-waiting-time.
// Revision : 1.0 - initial release
// ============================================================================
module queue_manager #(
    parameter int DEPTH    = 15,
    parameter int TELLERS  = 3,
    parameter int SVC_TIME = 3,
    parameter int TKW      = 8,
    localparam int CW      = $clog2(DEPTH + 1),
    localparam int TW      = $clog2(TELLERS + 1),
    localparam int WTW     = $clog2(DEPTH * SVC_TIME + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               arrive,
    input  logic               depart,
    input  logic [TELLERS-1:0] teller,
    output logic [CW-1:0]      pcount,
    output logic [TW-1:0]      tcount,
    output logic [WTW-1:0]     wtime,
    output logic               full,
    output logic               empty,
    output logic               alarm,
    output logic [TKW-1:0]     next_ticket,
    output logic [TKW-1:0]     serve_ticket
);

    localparam int PW = WTW + TW;

    logic [CW-1:0]  r_pcount;
    logic [TW-1:0]  r_tcount;
    logic [WTW-1:0] r_wtime;
    logic           r_alarm;
    logic [TKW-1:0] r_next;
    logic [TKW-1:0] r_serve;

    logic           w_dep_ok;
    logic           w_arr_ok;
    logic [TW-1:0]  w_pop;
    logic [PW-1:0]  w_prod;
    logic [WTW-1:0] w_quo;
    logic [WTW-1:0] w_wnext;

    assign w_dep_ok = depart && (r_pcount != '0) && (r_tcount != '0);
    // A depart in the same cycle frees the slot for a simultaneous arrival.
    assign w_arr_ok = arrive && ((r_pcount != CW'(DEPTH)) || w_dep_ok);

    always_comb begin
        w_pop = '0;
        for (int i = 0; i < TELLERS; i++) begin
            w_pop = w_pop + TW'(teller[i]);
        end
    end

    // Ceiling division by each possible constant teller count, selected by tcount.
    always_comb begin
        w_prod = PW'(r_pcount) * PW'(SVC_TIME);
        w_quo  = '0;
        for (int t = 1; t <= TELLERS; t++) begin
            if (r_tcount == TW'(t)) begin
                w_quo = WTW'((w_prod + PW'(t - 1)) / PW'(t));
            end
        end
    end

    always_comb begin
        w_wnext = w_quo;
        if (r_pcount == '0) begin
            w_wnext = '0;
        end else if (r_tcount == '0) begin
            w_wnext = '1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pcount <= '0;
            r_tcount <= '0;
            r_wtime  <= '0;
            r_alarm  <= 1'b0;
            r_next   <= '0;
            r_serve  <= '0;
        end else begin
            r_tcount <= w_pop;
            r_wtime  <= w_wnext;
            r_alarm  <= (arrive && !w_arr_ok) || (depart && !w_dep_ok);
            if (w_arr_ok && !w_dep_ok) begin
                r_pcount <= r_pcount + CW'(1);
            end else if (w_dep_ok && !w_arr_ok) begin
                r_pcount <= r_pcount - CW'(1);
            end
            if (w_arr_ok) begin
                r_next <= r_next + TKW'(1);
            end
            if (w_dep_ok) begin
                r_serve <= r_serve + TKW'(1);
            end
        end
    end

    assign pcount       = r_pcount;
    assign tcount       = r_tcount;
    assign wtime        = r_wtime;
    assign alarm        = r_alarm;
    assign next_ticket  = r_next;
    assign serve_ticket = r_serve;
    assign full         = (r_pcount == CW'(DEPTH));
    assign empty        = (r_pcount == '0);

endmodule
`default_nettype wire

// File: tb/tb_queue_manager.sv
`default_nettype none
// ============================================================================
// Module   : tb_queue_manager
// Purpose  : Directed plus random checks of two queue_manager configurations
//            against an integer reference model of the queue rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_queue_manager;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       arr0, dep0, arr1, dep1;
    logic [2:0] tel0, tel1;

    logic [3:0] pc0;  logic [1:0] tc0; logic [5:0] wt0;
    logic       f0, e0, al0;  logic [7:0] nt0, st0;
    logic [1:0] pc1;  logic [1:0] tc1; logic [3:0] wt1;
    logic       f1, e1, al1;  logic [3:0] nt1, st1;

    queue_manager u_big (
        .clk(clk), .reset(reset), .arrive(arr0), .depart(dep0), .teller(tel0),
        .pcount(pc0), .tcount(tc0), .wtime(wt0), .full(f0), .empty(e0),
        .alarm(al0), .next_ticket(nt0), .serve_ticket(st0)
    );

    queue_manager #(.DEPTH(3), .TELLERS(3), .SVC_TIME(3), .TKW(4)) u_small (
        .clk(clk), .reset(reset), .arrive(arr1), .depart(dep1), .teller(tel1),
        .pcount(pc1), .tcount(tc1), .wtime(wt1), .full(f1), .empty(e1),
        .alarm(al1), .next_ticket(nt1), .serve_ticket(st1)
    );

    int total = 0;
    int bad   = 0;

    int md[2]   = '{15, 3};
    int mk[2]   = '{8, 4};
    int mmax[2] = '{63, 15};
    int mp[2], mt[2], mw[2], mn[2], ms[2], ma[2];

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            mp[i] = 0; mt[i] = 0; mw[i] = 0; mn[i] = 0; ms[i] = 0; ma[i] = 0;
        end
    endtask

    // One rising edge of the queue, from the rules on queue length and ticket numbers.
    task automatic model_edge(input int id, input bit a, input bit d, input logic [2:0] tel);
        bit dok, aok;
        int w;
        dok = d && (mp[id] > 0) && (mt[id] > 0);
        aok = a && ((mp[id] < md[id]) || dok);
        if (mp[id] == 0)      w = 0;
        else if (mt[id] == 0) w = mmax[id];
        else                  w = (mp[id] * 3 + mt[id] - 1) / mt[id];
        ma[id] = ((a && !aok) || (d && !dok)) ? 1 : 0;
        mp[id] = mp[id] + int'(aok) - int'(dok);
        mn[id] = (mn[id] + int'(aok)) % (1 << mk[id]);
        ms[id] = (ms[id] + int'(dok)) % (1 << mk[id]);
        mt[id] = $countones(tel);
        mw[id] = w;
    endtask

    task automatic check_all(input int id);
        int p, t, w, f, e, a, n, s, m;
        m = 1 << mk[id];
        if (id == 0) begin
            p = int'(pc0); t = int'(tc0); w = int'(wt0); f = int'(f0);
            e = int'(e0); a = int'(al0); n = int'(nt0); s = int'(st0);
        end else begin
            p = int'(pc1); t = int'(tc1); w = int'(wt1); f = int'(f1);
            e = int'(e1); a = int'(al1); n = int'(nt1); s = int'(st1);
        end
        chk($sformatf("pcount%0d", id), p, mp[id]);
        chk($sformatf("tcount%0d", id), t, mt[id]);
        chk($sformatf("wtime%0d", id), w, mw[id]);
        chk($sformatf("full%0d", id), f, (mp[id] == md[id]) ? 1 : 0);
        chk($sformatf("empty%0d", id), e, (mp[id] == 0) ? 1 : 0);
        chk($sformatf("alarm%0d", id), a, ma[id]);
        chk($sformatf("next%0d", id), n, mn[id]);
        chk($sformatf("serve%0d", id), s, ms[id]);
        chk($sformatf("invariant%0d", id), (n - s + m) % m, p);
    endtask

    task automatic cycle(input bit a0, input bit d0, input logic [2:0] t0,
                         input bit a1, input bit d1, input logic [2:0] t1);
        arr0 = a0; dep0 = d0; tel0 = t0;
        arr1 = a1; dep1 = d1; tel1 = t1;
        @(posedge clk);
        #1;
        model_edge(0, a0, d0, t0);
        model_edge(1, a1, d1, t1);
        arr0 = 1'b0; dep0 = 1'b0; arr1 = 1'b0; dep1 = 1'b0;
        check_all(0);
        check_all(1);
    endtask

    // Big instance only; small one idles with no teller.
    task automatic big(input bit a, input bit d, input logic [2:0] t);
        cycle(a, d, t, 1'b0, 1'b0, 3'b000);
    endtask

    initial begin
        reset = 1'b1;
        arr0 = 1'b0; dep0 = 1'b0; tel0 = 3'b000;
        arr1 = 1'b0; dep1 = 1'b0; tel1 = 3'b000;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all(0);
        check_all(1);
        reset = 1'b0;

        // Tellers open
        big(0, 0, 3'b011);
        big(0, 0, 3'b011);
        chk("tp_tcount", int'(tc0), 2);
        chk("tp_empty", int'(e0), 1);
        chk("tp_wtime0", int'(wt0), 0);
        repeat (7) big(1, 0, 3'b011);
        chk("tp_pcount7", int'(pc0), 7);
        chk("tp_next7", int'(nt0), 7);
        big(0, 0, 3'b011);
        chk("tp_wtime11", int'(wt0), 11);

        // Fill and overflow
        repeat (8) big(1, 0, 3'b011);
        chk("tp_full", int'(f0), 1);
        big(1, 0, 3'b011);
        chk("tp_ovf_pcount", int'(pc0), 15);
        chk("tp_ovf_next", int'(nt0), 15);
        chk("tp_ovf_alarm", int'(al0), 1);
        big(1, 1, 3'b011);
        chk("tp_swap_pcount", int'(pc0), 15);
        chk("tp_swap_next", int'(nt0), 16);
        chk("tp_swap_serve", int'(st0), 1);
        chk("tp_swap_alarm", int'(al0), 0);

        // No teller open
        repeat (10) big(0, 1, 3'b011);
        chk("tp_pcount5", int'(pc0), 5);
        big(0, 0, 3'b000);
        big(0, 1, 3'b000);
        chk("tp_noteller_pcount", int'(pc0), 5);
        chk("tp_noteller_alarm", int'(al0), 1);
        chk("tp_noteller_wtime", int'(wt0), 63);

        // Drain; the depart in the cycle tellers reopen is rejected
        big(0, 1, 3'b111);
        chk("tp_reopen_alarm", int'(al0), 1);
        repeat (5) big(0, 1, 3'b111);
        chk("tp_drained_empty", int'(e0), 1);
        chk("tp_drained_tickets", int'(st0), int'(nt0));
        big(0, 1, 3'b111);
        chk("tp_underflow_alarm", int'(al0), 1);
        chk("tp_underflow_serve", int'(st0), 16);

        // Random traffic on the big instance
        for (int i = 0; i < 300; i++) begin
            big(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 7) == 0) ? 3'b000 : 3'($urandom));
        end

        // Ticket wrap on the small instance
        cycle(0, 0, 3'b111, 0, 0, 3'b001);
        repeat (20) cycle(0, 0, 3'b111, 1, 1, 3'b001);
        chk("tp_wrap_next", int'(nt1), 4);
        chk("tp_wrap_serve", int'(st1), 3);
        for (int i = 0; i < 200; i++) begin
            cycle(0, 0, 3'b111, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  3'($urandom));
        end

        // Asynchronous reset mid-operation
        @(posedge clk);
        #1;
        reset = 1'b1;
        #2;
        model_reset();
        reset = 1'b0;
        repeat (9) big(1, 0, 3'b111);
        chk("tp_pcount9", int'(pc0), 9);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_all(0);
        check_all(1);
        reset = 1'b0;
        big(1, 0, 3'b111);
        chk("tp_after_reset", int'(pc0), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
